// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the RV32M multi-cycle multiply/divide sequencer:
// op codes, FSM state encoding and op-classification helpers.
package alu_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_step.sv
// One iteration of the shared datapath: shift-add multiply step or
// restoring divide step, selected by div_mode.
module muldiv_step
  import alu_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            div_mode,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] shreg,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] shreg_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;

  // Multiply keeps the high product half in acc and shifts low bits into shreg;
  // divide shifts the dividend MSB into the partial remainder in acc.
  always_comb begin
    sum        = '0;
    rem_sh     = '0;
    diff       = '0;
    acc_next   = acc;
    shreg_next = shreg;
    if (div_mode) begin
      rem_sh = {acc, shreg[XLEN-1]};
      diff   = rem_sh[XLEN-1:0] - operand;
      if (rem_sh >= {1'b0, operand}) begin
        acc_next   = diff;
        shreg_next = {shreg[XLEN-2:0], 1'b1};
      end else begin
        acc_next   = rem_sh[XLEN-1:0];
        shreg_next = {shreg[XLEN-2:0], 1'b0};
      end
    end else begin
      sum        = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
      acc_next   = sum[XLEN:1];
      shreg_next = {sum[0], shreg[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M sequencer: accepts one op over valid/ready, iterates
// XLEN cycles on operand magnitudes, sign-corrects and holds the result.
module alu_muldiv_seq
  import alu_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   shreg_q, shreg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   step_acc, step_shreg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              a_neg, b_neg;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   int_min;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_mode   (is_div(op_q)),
    .acc        (acc_q),
    .shreg      (shreg_q),
    .operand    (opnd_q),
    .acc_next   (step_acc),
    .shreg_next (step_shreg)
  );

  assign req_ready  = (state_q == IDLE) && !flush;
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == DONE);
  assign result     = result_q;

  // Operand magnitudes and the sign correction applied to the last iteration's output.
  always_comb begin
    int_min  = {1'b1, {(XLEN-1){1'b0}}};
    a_neg    = is_signed_a(req_op) && rs1[XLEN-1];
    b_neg    = is_signed_b(req_op) && rs2[XLEN-1];
    a_abs    = a_neg ? -rs1 : rs1;
    b_abs    = b_neg ? -rs2 : rs2;
    prod_fix = (neg_a_q ^ neg_b_q) ? -{step_acc, step_shreg} : {step_acc, step_shreg};
    quo_fix  = (neg_a_q ^ neg_b_q) ? -step_shreg : step_shreg;
    rem_fix  = neg_a_q ? -step_acc : step_acc;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    shreg_d  = shreg_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_d    = req_op;
          neg_a_d = a_neg;
          neg_b_d = b_neg;
          cnt_d   = '0;
          acc_d   = '0;
          shreg_d = is_div(req_op) ? a_abs : b_abs;
          opnd_d  = is_div(req_op) ? b_abs : a_abs;
          state_d = CALC;
          if (is_div(req_op) && (rs2 == '0)) begin
            result_d = req_op[1] ? rs1 : '1;
            state_d  = DONE;
          end else if (((req_op == OP_DIV) || (req_op == OP_REM)) &&
                       (rs1 == int_min) && (rs2 == '1)) begin
            result_d = (req_op == OP_DIV) ? int_min : '0;
            state_d  = DONE;
          end
        end
      end
      CALC: begin
        acc_d   = step_acc;
        shreg_d = step_shreg;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d = DONE;
          if (is_div(op_q)) begin
            result_d = op_q[1] ? rem_fix : quo_fix;
          end else begin
            result_d = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
          end
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A redirect kills whatever is in flight but leaves the last result visible.
    if (flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      shreg_q  <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shreg_q  <= shreg_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed RV32M vectors, random ops
// against an arithmetic reference model, backpressure, flush and async reset.
module tb_alu_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_muldiv_seq #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .rs1        (rs1),
    .rs2        (rs2),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model straight from RV32M arithmetic rules.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub, up;
    longint          sp;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op, scramble operands after acceptance, wait for and accept the response.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    rs1       = a;
    rs2       = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rs1       = $urandom;
    rs2       = $urandom;
    req_op    = 3'($urandom);
    lat       = -1;
    res       = 'x;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = k;
        res = result;
        break;
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 3'd0;
    rs1        = '0;
    rs2        = '0;
    flush      = 1'b0;
    resp_ready = 1'b0;
    #1;
    tests_run++;
    if (resp_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_resp_valid got %b want 0", resp_valid);
    end
    tests_run++;
    if (result !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_result got %h want 0", result);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_busy got %b want 0", busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_req_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [14] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd5, 3'd6, 3'd4, 3'd6, 3'd0, 3'd7};
    logic [31:0] as  [14] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                              32'h1234_5678, 32'd42};
    logic [31:0] bs  [14] = '{32'd6, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd0, 32'd0};
    logic [31:0] exp [14] = '{32'd42, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                              32'd0, 32'd42};
    int          lats[14] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 33, 1};
    logic [31:0] res;
    int          lat;
    for (int i = 0; i < 14; i++) begin
      do_op(ops[i], as[i], bs[i], res, lat);
      tests_run++;
      if (res !== exp[i]) begin
        tests_failed++;
        $display("[TB] FAIL directed_%0d_result op=%0d got %h want %h", i, ops[i], res, exp[i]);
      end
      tests_run++;
      if (lat !== lats[i]) begin
        tests_failed++;
        $display("[TB] FAIL directed_%0d_latency op=%0d got %0d want %0d", i, ops[i], lat, lats[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [2:0]  op;
    logic [31:0] a, b, res;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 5) == 0) b = b >> $urandom_range(16, 31);
      do_op(op, a, b, res, lat);
      tests_run++;
      if (res !== model(op, a, b) || lat !== model_latency(op, a, b)) begin
        tests_failed++;
        $display("[TB] FAIL random_%0d op=%0d a=%h b=%h got %h/%0d want %h/%0d",
                 i, op, a, b, res, lat, model(op, a, b), model_latency(op, a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    int          lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd0;
    rs1       = 32'd7;
    rs2       = 32'd6;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("[TB] FAIL bp_latency got %0d want 33", lat);
    end
    held      = 32'd42;
    req_valid = 1'b1;
    req_op    = 3'd5;
    rs1       = 32'd100;
    rs2       = 32'd7;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      tests_run++;
      if (resp_valid !== 1'b1 || result !== held || req_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold_%0d got valid=%b result=%h ready=%b want 1/%h/0",
                 i, resp_valid, result, req_ready, held);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_no_same_cycle_accept got busy=%b ready=%b want 0/1", busy, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_next_accept got busy=%b want 1", busy);
    end
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    tests_run++;
    if (lat !== 33 || result !== 32'd14) begin
      tests_failed++;
      $display("[TB] FAIL bp_second_op got %h/%0d want 0000000e/33", result, lat);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int          lat;
    bit          seen;
    do_op(3'd5, 32'd100, 32'd7, res, lat);
    tests_run++;
    if (res !== 32'd14) begin
      tests_failed++;
      $display("[TB] FAIL flush_setup got %h want 0000000e", res);
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd4;
    rs1       = 32'd1000;
    rs2       = 32'hFFFF_FFF9;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = 3'd0;
    #1;
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL flush_req_ready got %b want 0", req_ready);
    end
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || result !== 32'd14) begin
      tests_failed++;
      $display("[TB] FAIL flush_state got busy=%b valid=%b result=%h want 0/0/0000000e",
               busy, resp_valid, result);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL flush_no_response got activity=%b want 0", seen);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] res;
    int          lat;
    bit          seen;
    do_op(3'd0, 32'd3, 32'd5, res, lat);
    tests_run++;
    if (res !== 32'd15) begin
      tests_failed++;
      $display("[TB] FAIL rst_setup got %h want 0000000f", res);
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd5;
    rs1       = 32'd99;
    rs2       = 32'd4;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || result !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_calc got busy=%b valid=%b result=%h want 0/0/0",
               busy, resp_valid, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_no_response got %b want 0", seen);
    end
    do_op(3'd5, 32'd9, 32'd3, res, lat);
    tests_run++;
    if (res !== 32'd3 || lat !== 33) begin
      tests_failed++;
      $display("[TB] FAIL rst_followup got %h/%0d want 00000003/33", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid_calc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
